// File: rtl/cntr_updn_mod.sv
// Modulo-N up/down counter with synchronous clear/load, a combinational
// cascade carry, and a sticky wrap/saturation flag.
module cntr_updn_mod #(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
    parameter int              SAT_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_async_b,
    input  logic             clr_sync_b,
    input  logic             cnt_en,
    input  logic             up_dn,
    input  logic             ld_en,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] cnt,
    output logic             carry,
    output logic             ovf
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("cntr_updn_mod: WIDTH %0d outside 2..32", WIDTH);
    end
    if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("cntr_updn_mod: MODULUS %0d outside 2..2**WIDTH", MODULUS);
    end
    if (SAT_MODE != 0 && SAT_MODE != 1) begin : g_bad_sat
        $error("cntr_updn_mod: SAT_MODE %0d must be 0 or 1", SAT_MODE);
    end

    localparam logic [WIDTH-1:0] TERM_HI = WIDTH'(MODULUS - 64'd1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             at_term;

    assign at_term = up_dn ? (cnt_q == TERM_HI) : (cnt_q == '0);

    // Carry is gated by the same priority as the register update, so a
    // cleared or loaded stage never advances the next digit.
    assign carry = clr_sync_b & ~ld_en & cnt_en & at_term;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (!clr_sync_b) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (ld_en) begin
            cnt_d = (64'(ld_val) < MODULUS) ? ld_val : TERM_HI;
            ovf_d = 1'b0;
        end else if (cnt_en) begin
            if (at_term) begin
                ovf_d = 1'b1;
                if (SAT_MODE == 0) begin
                    cnt_d = up_dn ? '0 : TERM_HI;
                end
            end else begin
                cnt_d = up_dn ? (cnt_q + WIDTH'(1)) : (cnt_q - WIDTH'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_async_b) begin
        if (!rst_async_b) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_cntr_updn_mod.sv
// Directed bench for cntr_updn_mod: wrap and saturate instances plus a
// two-digit decimal chain built from carry -> cnt_en.
module tb_cntr_updn_mod;

    logic clk;
    int   checks = 0;
    int   passed = 0;

    // wrapping decade counter
    logic       a_rst, a_clr, a_en, a_up, a_ld;
    logic [3:0] a_ldv, a_cnt;
    logic       a_carry, a_ovf;

    // saturating decade counter
    logic       s_rst, s_clr, s_en, s_up, s_ld;
    logic [3:0] s_ldv, s_cnt;
    logic       s_carry, s_ovf;

    // two chained decade counters
    logic       c_rst, c_clr, c_en, c_up, c_ld;
    logic [3:0] c_ldv, c_lo_cnt, c_hi_cnt;
    logic       c_lo_carry, c_hi_carry, c_lo_ovf, c_hi_ovf;

    cntr_updn_mod #(.WIDTH(4), .MODULUS(10), .SAT_MODE(0)) u_wrap (
        .clk(clk), .rst_async_b(a_rst), .clr_sync_b(a_clr), .cnt_en(a_en),
        .up_dn(a_up), .ld_en(a_ld), .ld_val(a_ldv), .cnt(a_cnt),
        .carry(a_carry), .ovf(a_ovf)
    );

    cntr_updn_mod #(.WIDTH(4), .MODULUS(10), .SAT_MODE(1)) u_sat (
        .clk(clk), .rst_async_b(s_rst), .clr_sync_b(s_clr), .cnt_en(s_en),
        .up_dn(s_up), .ld_en(s_ld), .ld_val(s_ldv), .cnt(s_cnt),
        .carry(s_carry), .ovf(s_ovf)
    );

    cntr_updn_mod #(.WIDTH(4), .MODULUS(10), .SAT_MODE(0)) u_lo (
        .clk(clk), .rst_async_b(c_rst), .clr_sync_b(c_clr), .cnt_en(c_en),
        .up_dn(c_up), .ld_en(c_ld), .ld_val(c_ldv), .cnt(c_lo_cnt),
        .carry(c_lo_carry), .ovf(c_lo_ovf)
    );

    cntr_updn_mod #(.WIDTH(4), .MODULUS(10), .SAT_MODE(0)) u_hi (
        .clk(clk), .rst_async_b(c_rst), .clr_sync_b(c_clr), .cnt_en(c_lo_carry),
        .up_dn(c_up), .ld_en(c_ld), .ld_val(c_ldv), .cnt(c_hi_cnt),
        .carry(c_hi_carry), .ovf(c_hi_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 0; a_clr = 1; a_en = 1; a_up = 0; a_ld = 0; a_ldv = 4'd0;
        s_rst = 0; s_clr = 1; s_en = 0; s_up = 1; s_ld = 0; s_ldv = 4'd0;
        c_rst = 0; c_clr = 1; c_en = 0; c_up = 1; c_ld = 0; c_ldv = 4'd0;
        #2;
        checks++;
        if (a_cnt !== 4'd0 || a_ovf !== 1'b0)
            $display("FAIL reset_state cnt=%0d ovf=%b exp cnt=0 ovf=0", a_cnt, a_ovf);
        else passed++;
        checks++;
        if (a_carry !== 1'b1)
            $display("FAIL reset_carry_down got %b exp 1", a_carry);
        else passed++;
        a_up = 1;
        #1;
        checks++;
        if (a_carry !== 1'b0)
            $display("FAIL reset_carry_up got %b exp 0", a_carry);
        else passed++;
        a_en = 0;
        a_rst = 1; s_rst = 1; c_rst = 1;
        tick();
    endtask

    task automatic test_count_up();
        int exp_cnt[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        int prev = 0;
        a_en = 1; a_up = 1;
        for (int i = 0; i < 12; i++) begin
            #1;
            checks++;
            if (a_carry !== (prev == 9))
                $display("FAIL up_carry[%0d] got %b exp %b", i, a_carry, (prev == 9));
            else passed++;
            tick();
            checks++;
            if (a_cnt !== 4'(exp_cnt[i]) || a_ovf !== (i >= 9))
                $display("FAIL up_step[%0d] cnt=%0d ovf=%b exp cnt=%0d ovf=%b",
                         i, a_cnt, a_ovf, exp_cnt[i], (i >= 9));
            else passed++;
            prev = exp_cnt[i];
        end
        a_en = 0;
    endtask

    task automatic test_count_down();
        int exp_cnt[4] = '{9, 8, 7, 6};
        a_clr = 0;
        tick();
        checks++;
        if (a_cnt !== 4'd0 || a_ovf !== 1'b0)
            $display("FAIL down_clear cnt=%0d ovf=%b exp cnt=0 ovf=0", a_cnt, a_ovf);
        else passed++;
        a_clr = 1; a_up = 0; a_en = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (a_carry !== (i == 0))
                $display("FAIL down_carry[%0d] got %b exp %b", i, a_carry, (i == 0));
            else passed++;
            tick();
            checks++;
            if (a_cnt !== 4'(exp_cnt[i]) || a_ovf !== 1'b1)
                $display("FAIL down_step[%0d] cnt=%0d ovf=%b exp cnt=%0d ovf=1",
                         i, a_cnt, a_ovf, exp_cnt[i]);
            else passed++;
        end
        a_en = 0;
    endtask

    task automatic test_hold();
        a_en = 0; a_up = 0;
        tick(); tick(); tick();
        checks++;
        if (a_cnt !== 4'd6 || a_ovf !== 1'b1 || a_carry !== 1'b0)
            $display("FAIL hold cnt=%0d ovf=%b carry=%b exp cnt=6 ovf=1 carry=0",
                     a_cnt, a_ovf, a_carry);
        else passed++;
    endtask

    task automatic test_direction();
        logic dir[4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
        int   exp_c[4] = '{7, 6, 5, 6};
        a_en = 1;
        for (int i = 0; i < 4; i++) begin
            a_up = dir[i];
            tick();
            checks++;
            if (a_cnt !== 4'(exp_c[i]))
                $display("FAIL direction[%0d] got %0d exp %0d", i, a_cnt, exp_c[i]);
            else passed++;
        end
        a_up = 0;
        tick();
        checks++;
        if (a_cnt !== 4'd5 || a_ovf !== 1'b1)
            $display("FAIL dir_to5 cnt=%0d ovf=%b exp cnt=5 ovf=1", a_cnt, a_ovf);
        else passed++;
    endtask

    task automatic test_clear_priority();
        a_clr = 0; a_ld = 1; a_ldv = 4'd7; a_en = 1; a_up = 1;
        #1;
        checks++;
        if (a_carry !== 1'b0)
            $display("FAIL clr_carry got %b exp 0", a_carry);
        else passed++;
        tick();
        checks++;
        if (a_cnt !== 4'd0 || a_ovf !== 1'b0)
            $display("FAIL clr_priority cnt=%0d ovf=%b exp cnt=0 ovf=0", a_cnt, a_ovf);
        else passed++;
        a_ld = 0; a_up = 0;
        #1;
        checks++;
        if (a_carry !== 1'b0)
            $display("FAIL clr_masks_carry got %b exp 0", a_carry);
        else passed++;
        a_clr = 1;
        #1;
        checks++;
        if (a_carry !== 1'b1)
            $display("FAIL carry_at_zero_down got %b exp 1", a_carry);
        else passed++;
        a_en = 0;
        tick();
    endtask

    task automatic test_load();
        logic [3:0] vals[4]  = '{4'd3, 4'd12, 4'd10, 4'd0};
        int         exp_c[4] = '{3, 9, 9, 0};
        a_ld = 1; a_en = 0;
        for (int i = 0; i < 4; i++) begin
            a_ldv = vals[i];
            tick();
            checks++;
            if (a_cnt !== 4'(exp_c[i]) || a_ovf !== 1'b0)
                $display("FAIL load[%0d] cnt=%0d ovf=%b exp cnt=%0d ovf=0",
                         i, a_cnt, a_ovf, exp_c[i]);
            else passed++;
        end
        // load 9, then load 4 with count enabled at the terminal value
        a_ldv = 4'd9;
        tick();
        a_en = 1; a_up = 1; a_ldv = 4'd4;
        #1;
        checks++;
        if (a_carry !== 1'b0)
            $display("FAIL load_masks_carry got %b exp 0", a_carry);
        else passed++;
        tick();
        checks++;
        if (a_cnt !== 4'd4)
            $display("FAIL load_over_count got %0d exp 4", a_cnt);
        else passed++;
        a_ldv = 4'd0;
        tick();
        a_ld = 0; a_up = 0;
        tick();
        checks++;
        if (a_cnt !== 4'd9 || a_ovf !== 1'b1)
            $display("FAIL wrap_down cnt=%0d ovf=%b exp cnt=9 ovf=1", a_cnt, a_ovf);
        else passed++;
        a_ld = 1; a_en = 0; a_ldv = 4'd15;
        tick();
        checks++;
        if (a_cnt !== 4'd9 || a_ovf !== 1'b0)
            $display("FAIL load_clears_ovf cnt=%0d ovf=%b exp cnt=9 ovf=0", a_cnt, a_ovf);
        else passed++;
        a_ld = 0;
    endtask

    task automatic test_sat();
        s_ld = 1; s_ldv = 4'd8;
        tick();
        s_ld = 0; s_en = 1; s_up = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (s_carry !== (i != 0))
                $display("FAIL sat_carry[%0d] got %b exp %b", i, s_carry, (i != 0));
            else passed++;
            tick();
            checks++;
            if (s_cnt !== 4'd9 || s_ovf !== (i >= 1))
                $display("FAIL sat_up[%0d] cnt=%0d ovf=%b exp cnt=9 ovf=%b",
                         i, s_cnt, s_ovf, (i >= 1));
            else passed++;
        end
        s_ld = 1; s_ldv = 4'd12;
        tick();
        checks++;
        if (s_cnt !== 4'd9 || s_ovf !== 1'b0)
            $display("FAIL sat_load_clamp cnt=%0d ovf=%b exp cnt=9 ovf=0", s_cnt, s_ovf);
        else passed++;
        s_ldv = 4'd0;
        tick();
        s_ld = 0; s_up = 0;
        tick();
        checks++;
        if (s_cnt !== 4'd0 || s_ovf !== 1'b1)
            $display("FAIL sat_down cnt=%0d ovf=%b exp cnt=0 ovf=1", s_cnt, s_ovf);
        else passed++;
        s_en = 0;
    endtask

    task automatic test_async_reset();
        a_ld = 1; a_ldv = 4'd0; a_en = 0;
        tick();
        a_ld = 0; a_en = 1; a_up = 0;
        tick(); tick(); tick();
        checks++;
        if (a_cnt !== 4'd7 || a_ovf !== 1'b1)
            $display("FAIL arst_setup cnt=%0d ovf=%b exp cnt=7 ovf=1", a_cnt, a_ovf);
        else passed++;
        a_up = 1;
        #2;
        a_rst = 0;
        #1;
        checks++;
        if (a_cnt !== 4'd0 || a_ovf !== 1'b0)
            $display("FAIL arst_immediate cnt=%0d ovf=%b exp cnt=0 ovf=0", a_cnt, a_ovf);
        else passed++;
        tick();
        checks++;
        if (a_cnt !== 4'd0)
            $display("FAIL arst_hold got %0d exp 0", a_cnt);
        else passed++;
        #1;
        a_rst = 1;
        tick();
        checks++;
        if (a_cnt !== 4'd1 || a_ovf !== 1'b0)
            $display("FAIL arst_resume cnt=%0d ovf=%b exp cnt=1 ovf=0", a_cnt, a_ovf);
        else passed++;
        a_en = 0;
    endtask

    task automatic test_chain();
        c_clr = 0;
        tick();
        c_clr = 1; c_up = 1; c_en = 1;
        for (int k = 1; k <= 100; k++) begin
            if (k == 100) begin
                checks++;
                if (c_hi_carry !== 1'b1)
                    $display("FAIL chain_hi_carry got %b exp 1", c_hi_carry);
                else passed++;
            end
            tick();
            checks++;
            if (c_lo_cnt !== 4'(k % 10) || c_hi_cnt !== 4'((k / 10) % 10) ||
                c_hi_ovf !== (k == 100))
                $display("FAIL chain[%0d] hi=%0d lo=%0d hovf=%b exp hi=%0d lo=%0d hovf=%b",
                         k, c_hi_cnt, c_lo_cnt, c_hi_ovf, (k / 10) % 10, k % 10, (k == 100));
            else passed++;
        end
        checks++;
        if (c_lo_ovf !== 1'b1)
            $display("FAIL chain_lo_ovf got %b exp 1", c_lo_ovf);
        else passed++;
        c_en = 0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_hold();
        test_direction();
        test_clear_priority();
        test_load();
        test_sat();
        test_async_reset();
        test_chain();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
